// File: rtl/serial_add_sub_if.sv
// Handshake and data bundle for serial_add_sub.
//   start/mode/A/B/C_in : request side, driven by the master
//   ready/done          : idle indication and one-cycle result strobe
//   S/C_out/V           : result, raw carry out of the MSB, signed overflow
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             V;

  modport master (
    output start, mode, A, B, C_in,
    input  ready, done, S, C_out, V
  );

  modport slave (
    input  start, mode, A, B, C_in,
    output ready, done, S, C_out, V
  );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor processing DIGIT bits of a WIDTH-bit operand pair per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_sub_if slave (start/mode/A/B/C_in in; ready/done/S/C_out/V out)
// Add computes A + B + C_in; subtract computes A + ~B + ~C_in (A - B - C_in). A request is
// accepted only while idle; the result appears WIDTH/DIGIT cycles later with a one-cycle done.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);

  localparam int unsigned NumDigits = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_add_sub: WIDTH must be at least 2");
  end
  if (DIGIT == 0 || DIGIT > WIDTH || ((DIGIT == 0) ? 1 : (WIDTH % DIGIT)) != 0)
  begin : g_bad_digit
    $error("serial_add_sub: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              v_q, v_d;

  logic [DIGIT:0]    dsum;
  logic              c_into_msb;
  logic [WIDTH-1:0]  a_shift;
  logic [WIDTH-1:0]  b_shift;

  // Digit adder on the low DIGIT bits of the operand registers.
  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // Carry into the top bit of the digit; on the final digit this is the carry into the MSB.
  assign c_into_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  // The partial sum is shifted into the top of the A register as its LSBs are consumed, so
  // after the last digit a_shift holds the full result.
  if (DIGIT < WIDTH) begin : g_shift
    assign a_shift = {dsum[DIGIT-1:0], a_q[WIDTH-1:DIGIT]};
    assign b_shift = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
  end else begin : g_no_shift
    assign a_shift = dsum[DIGIT-1:0];
    assign b_shift = '0;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.mode ? ~bus.B : bus.B;
          carry_d = bus.C_in ^ bus.mode;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_shift;
        b_d     = b_shift;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          s_d     = a_shift;
          cout_d  = dsum[DIGIT];
          v_d     = c_into_msb ^ dsum[DIGIT];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.done  = (state_q == StDone);
  assign bus.S     = s_q;
  assign bus.C_out = cout_q;
  assign bus.V     = v_q;

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  localparam int NumDut = 9;

  // DUT table: 0 W4D1, 1 W4D2, 2 W8D1, 3 W8D4, 4..8 W16 with DIGIT 1,2,4,8,16.
  function automatic int unsigned cfg_w(input int i);
    if (i < 2) return 4;
    if (i < 4) return 8;
    return 16;
  endfunction

  function automatic int unsigned cfg_d(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 1;
      5: return 2;
      6: return 4;
      7: return 8;
      default: return 16;
    endcase
  endfunction

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic pulse_n = 1'b1;

  logic        start_v [NumDut];
  logic        mode_v  [NumDut];
  logic [15:0] a_v     [NumDut];
  logic [15:0] b_v     [NumDut];
  logic        cin_v   [NumDut];
  wire         rdy_o   [NumDut];
  wire         done_o  [NumDut];
  wire  [15:0] s_o     [NumDut];
  wire         co_o    [NumDut];
  wire         v_o     [NumDut];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    localparam int unsigned W = cfg_w(g);
    localparam int unsigned D = cfg_d(g);
    serial_add_sub_if #(.WIDTH(W)) bus ();
    serial_add_sub #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n ((g == 3) ? (rst_n && pulse_n) : rst_n),
      .bus   (bus)
    );
    assign bus.start = start_v[g];
    assign bus.mode  = mode_v[g];
    assign bus.A     = a_v[g][W-1:0];
    assign bus.B     = b_v[g][W-1:0];
    assign bus.C_in  = cin_v[g];
    assign rdy_o[g]  = bus.ready;
    assign done_o[g] = bus.done;
    assign s_o[g]    = 16'(bus.S);
    assign co_o[g]   = bus.C_out;
    assign v_o[g]    = bus.V;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference result {V, C_out, S} from integer arithmetic and a signed range test.
  function automatic logic [17:0] golden(input int unsigned w, input logic m,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
    int unsigned mask, aa, bb, c, full;
    int sa, sb, sr, lim;
    logic co, v;
    mask = (32'd1 << w) - 1;
    aa   = 32'(a) & mask;
    bb   = (m ? ~32'(b) : 32'(b)) & mask;
    c    = 32'(cin ^ m);
    full = aa + bb + c;
    co   = full[w];
    lim  = int'(32'd1 << (w - 1));
    sa   = (int'(aa) >= lim) ? int'(aa) - 2 * lim : int'(aa);
    sb   = (int'(bb) >= lim) ? int'(bb) - 2 * lim : int'(bb);
    sr   = sa + sb + int'(c);
    v    = (sr >= lim) || (sr < -lim);
    return {v, co, 16'(full & mask)};
  endfunction

  // One request on DUT id: returns result, latency in edges after the accepting edge (-1 on
  // timeout), and flags for ready dropping, S holding during RUN, done pulse width, ready return.
  task automatic run_op(input int id, input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [15:0] s, output logic co, output logic v,
                        output int lat, output logic rd, output logic sh, output logic dp,
                        output logic rb);
    logic [15:0] s_prev;
    @(negedge clk);
    mode_v[id] = m; a_v[id] = a; b_v[id] = b; cin_v[id] = cin; start_v[id] = 1'b1;
    s_prev = s_o[id];
    @(posedge clk); #1;
    start_v[id] = 1'b0;
    // Disturb the inputs while running; the latched operands must be used.
    mode_v[id] = ~m; a_v[id] = ~a; b_v[id] = ~b; cin_v[id] = ~cin;
    rd  = !rdy_o[id];
    sh  = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done_o[id]) begin
        lat = c;
        break;
      end
      if (s_o[id] !== s_prev) sh = 1'b0;
    end
    s = s_o[id]; co = co_o[id]; v = v_o[id];
    dp = 1'b0; rb = 1'b0;
    if (lat != -1) begin
      @(posedge clk); #1;
      dp = !done_o[id];
      rb = rdy_o[id];
    end
  endtask

  task automatic do_op(input string tag, input int id, input logic m, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic [15:0] es,
                       input logic eco, input logic ev);
    logic [15:0] s;
    logic co, v, rd, sh, dp, rb;
    int lat;
    run_op(id, m, a, b, cin, s, co, v, lat, rd, sh, dp, rb);
    check({tag, ".latency"}, lat, cfg_w(id) / cfg_d(id));
    check({tag, ".S"}, s, es);
    check({tag, ".C_out"}, co, eco);
    check({tag, ".V"}, v, ev);
    check({tag, ".ready_drop"}, rd, 1'b1);
    check({tag, ".S_hold"}, sh, 1'b1);
    check({tag, ".done_pulse"}, dp, 1'b1);
    check({tag, ".ready_back"}, rb, 1'b1);
  endtask

  logic [7:0]  ha [40];
  logic [7:0]  hb [40];
  logic        hm [40];
  logic        hc [40];

  initial begin
    logic [15:0] s, ra, rb16;
    logic co, v, rd, sh, dp, rbk, m, cin;
    logic [17:0] e;
    int lat, dones;

    for (int i = 0; i < NumDut; i++) begin
      start_v[i] = 1'b0; mode_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
    end

    // Reset state.
    #3;
    for (int i = 0; i < NumDut; i++)
      check($sformatf("reset.%0d", i), {rdy_o[i], done_o[i], co_o[i], v_o[i], s_o[i]},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=4, DIGIT=1, add.
    do_op("w4d1.2p1",   0, 1'b0, 16'h2, 16'h1, 1'b0, 16'h3, 1'b0, 1'b0);
    do_op("w4d1.8p8",   0, 1'b0, 16'h8, 16'h8, 1'b0, 16'h0, 1'b1, 1'b1);
    do_op("w4d1.7p1",   0, 1'b0, 16'h7, 16'h1, 1'b0, 16'h8, 1'b0, 1'b1);
    do_op("w4d1.fp0c1", 0, 1'b0, 16'hf, 16'h0, 1'b1, 16'h0, 1'b1, 1'b0);

    // WIDTH=4, DIGIT=2, subtract.
    do_op("w4d2.5m3",   1, 1'b1, 16'h5, 16'h3, 1'b0, 16'h2, 1'b1, 1'b0);
    do_op("w4d2.3m5",   1, 1'b1, 16'h3, 16'h5, 1'b0, 16'he, 1'b0, 1'b0);
    do_op("w4d2.8m1",   1, 1'b1, 16'h8, 16'h1, 1'b0, 16'h7, 1'b1, 1'b1);
    do_op("w4d2.5m3b1", 1, 1'b1, 16'h5, 16'h3, 1'b1, 16'h1, 1'b1, 1'b0);

    // WIDTH=8, DIGIT=1, start held high with operands changing every cycle.
    for (int i = 0; i < 40; i++) begin
      ha[i] = 8'(i * 37 + 11);
      hb[i] = 8'(i * 91 + 3);
      hm[i] = ((i / 10) % 2) == 1;
      hc[i] = (i % 3) == 0;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start_v[2] = 1'b1; a_v[2] = 16'(ha[i]); b_v[2] = 16'(hb[i]);
      mode_v[2] = hm[i]; cin_v[2] = hc[i];
      @(posedge clk); #1;
      check($sformatf("held.done@%0d", i), done_o[2], (i % 10) == 8);
      check($sformatf("held.ready@%0d", i), rdy_o[2], (i % 10) == 9);
      if ((i % 10) == 8) begin
        e = golden(8, hm[i-8], 16'(ha[i-8]), 16'(hb[i-8]), hc[i-8]);
        check($sformatf("held.result@%0d", i), {v_o[2], co_o[2], s_o[2]}, e);
      end
    end
    @(negedge clk);
    start_v[2] = 1'b0;

    // WIDTH=8, DIGIT=4: asynchronous abort during RUN.
    do_op("w8d4.pre", 3, 1'b0, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 1'b0);
    @(negedge clk);
    start_v[3] = 1'b1; mode_v[3] = 1'b0; a_v[3] = 16'h56; b_v[3] = 16'h78; cin_v[3] = 1'b0;
    @(posedge clk); #1;
    start_v[3] = 1'b0;
    @(posedge clk); #1;
    pulse_n = 1'b0;
    #1;
    check("abort.outputs", {rdy_o[3], done_o[3], co_o[3], v_o[3], s_o[3]},
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    pulse_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done_o[3]) dones++;
    end
    check("abort.no_done", dones, 0);
    check("abort.idle_S", s_o[3], 16'h0000);
    do_op("w8d4.post", 3, 1'b0, 16'hff, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0);

    // Directed corner for DIGIT=WIDTH: single-cycle operation.
    do_op("w16d16.max", 8, 1'b0, 16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("w16d8.sub",  7, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hffff, 1'b0, 1'b0);

    // Sweep of WIDTH=16 configurations against the reference.
    for (int id = 4; id < NumDut; id++) begin
      for (int n = 0; n < 1000; n++) begin
        ra   = 16'($urandom);
        rb16 = 16'($urandom);
        m    = 1'($urandom_range(0, 1));
        cin  = 1'($urandom_range(0, 1));
        run_op(id, m, ra, rb16, cin, s, co, v, lat, rd, sh, dp, rbk);
        e = golden(16, m, ra, rb16, cin);
        check($sformatf("sweep.d%0d.%0d a=%h b=%h m=%b c=%b", cfg_d(id), n, ra, rb16, m, cin),
              {8'(lat), 4'(0), dp, rbk, v, co, s},
              {8'(16 / cfg_d(id)), 4'(0), 1'b1, 1'b1, e});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
